line_doubler: RTL

LINE_DOUBLER -- requirements
Module: line_doubler

---
 rtl/line_doubler_pkg.sv | 23 ++
 rtl/line_doubler_ram.sv | 28 ++
 rtl/line_doubler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/line_doubler_pkg.sv
// rtl/line_doubler_pkg.sv - line doubler constants, pixel type and scanline dimming helper
package line_doubler_pkg;

    localparam int LINE_MAX = 1024;
    localparam int ADDR_W   = 10;
    localparam int COL_W    = 6;

    localparam logic [ADDR_W-1:0] CNT_MAX = ADDR_W'(LINE_MAX - 1);

    typedef struct packed {
        logic [COL_W-1:0] r;
        logic [COL_W-1:0] g;
        logic [COL_W-1:0] b;
    } rgb_t;

    // c - (c*n >> 2); the product fits 8 bits for 6-bit colour and n <= 3
    function automatic logic [COL_W-1:0] scan_atten(input logic [COL_W-1:0] c, input logic [1:0] n);
        logic [7:0] prod;
        prod = {2'b00, c} * {6'b000000, n};
        return c - prod[7:2];
    endfunction

endpackage

// File: rtl/line_doubler_ram.sv
// rtl/line_doubler_ram.sv - two-bank line buffer, simple dual-port with registered read
module line_doubler_ram
    import line_doubler_pkg::*;
(
    input  logic                 clk_sys,
    input  logic                 i_we,
    input  logic [ADDR_W:0]      i_waddr,
    input  logic [3*COL_W-1:0]   i_wdata,
    input  logic                 i_re,
    input  logic [ADDR_W:0]      i_raddr,
    output logic [3*COL_W-1:0]   o_rdata
);

    logic [3*COL_W-1:0] r_mem [0:2*LINE_MAX-1];

    always_ff @(posedge clk_sys) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/line_doubler.sv
// rtl/line_doubler.sv - 2x scan-rate line doubler; phase-1 scanline dimming when LINE_DOUBLER_SCANLINES_EN is defined
module line_doubler
    import line_doubler_pkg::*;
(
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             ce_in,
    input  logic             ce_out,
    input  logic             hs_in,
    input  logic             vs_in,
    input  logic [COL_W-1:0] r_in,
    input  logic [COL_W-1:0] g_in,
    input  logic [COL_W-1:0] b_in,
    input  logic [1:0]       scanlines,
    output logic             hs_out,
    output logic             vs_out,
    output logic [COL_W-1:0] r_out,
    output logic [COL_W-1:0] g_out,
    output logic [COL_W-1:0] b_out
);

    logic               r_hs_prev;
    logic               r_wbank;
    logic               r_wsat;
    logic               r_line_ok;
    logic               r_vs_line;
    logic               r_phase;
    logic [ADDR_W-1:0]  r_wcnt;
    logic [ADDR_W-1:0]  r_line_len;
    logic [ADDR_W-1:0]  r_hs_cnt;
    logic [ADDR_W-1:0]  r_hs_width;
    logic [ADDR_W-1:0]  r_out_cnt;
    logic               r_p1_hs;
    logic               r_p1_vs;
    logic               r_p1_phase;
    logic               r_p1_valid;

    logic               w_hs_rise;
    logic               w_we;
    logic               w_wrap;
    logic [ADDR_W:0]    w_waddr;
    logic [ADDR_W:0]    w_raddr;
    logic [3*COL_W-1:0] w_rd_data;
    rgb_t               w_wr_pix;
    rgb_t               w_rd_pix;
    rgb_t               w_pix;

    assign w_hs_rise = ce_in & hs_in & ~r_hs_prev;
    // The sync-edge pixel opens the new line at address 0 of the new bank
    assign w_we      = ce_in & (w_hs_rise | ~r_wsat);
    assign w_waddr   = w_hs_rise ? {~r_wbank, {ADDR_W{1'b0}}} : {r_wbank, r_wcnt};
    assign w_raddr   = {~r_wbank, r_out_cnt};
    assign w_wr_pix  = {r_in, g_in, b_in};
    assign w_rd_pix  = w_rd_data;
    assign w_wrap    = ~r_phase & (r_line_len != '0) & (r_out_cnt == r_line_len - ADDR_W'(1));

    line_doubler_ram u_ram (
        .clk_sys (clk_sys),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wr_pix),
        .i_re    (ce_out),
        .i_raddr (w_raddr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_hs_prev  <= 1'b0;
            r_wbank    <= 1'b0;
            r_wsat     <= 1'b0;
            r_line_ok  <= 1'b0;
            r_vs_line  <= 1'b0;
            r_wcnt     <= '0;
            r_line_len <= '0;
            r_hs_cnt   <= '0;
            r_hs_width <= '0;
        end else if (ce_in) begin
            r_hs_prev <= hs_in;
            if (w_hs_rise) begin
                // A line cut short by reset is never shown
                r_line_len <= r_line_ok ? r_wcnt : '0;
                r_line_ok  <= 1'b1;
                r_wbank    <= ~r_wbank;
                r_wcnt     <= ADDR_W'(1);
                r_wsat     <= 1'b0;
                r_vs_line  <= vs_in;
            end else if (!r_wsat) begin
                if (r_wcnt == CNT_MAX) begin
                    r_wsat <= 1'b1;
                end else begin
                    r_wcnt <= r_wcnt + ADDR_W'(1);
                end
            end
            if (hs_in) begin
                if (!r_hs_prev) begin
                    r_hs_cnt <= ADDR_W'(1);
                end else if (r_hs_cnt != CNT_MAX) begin
                    r_hs_cnt <= r_hs_cnt + ADDR_W'(1);
                end
            end else if (r_hs_prev) begin
                r_hs_width <= r_hs_cnt;
            end
        end
    end

`ifdef LINE_DOUBLER_SCANLINES_EN
    always_comb begin
        w_pix = w_rd_pix;
        if (r_p1_phase) begin
            w_pix.r = scan_atten(w_rd_pix.r, scanlines);
            w_pix.g = scan_atten(w_rd_pix.g, scanlines);
            w_pix.b = scan_atten(w_rd_pix.b, scanlines);
        end
    end
`else
    logic w_unused_scan;
    assign w_unused_scan = ^{scanlines, r_p1_phase};
    assign w_pix = w_rd_pix;
`endif

    // Stage 1 travels with the RAM read; stage 2 is the output register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_out_cnt  <= '0;
            r_phase    <= 1'b0;
            r_p1_hs    <= 1'b0;
            r_p1_vs    <= 1'b0;
            r_p1_phase <= 1'b0;
            r_p1_valid <= 1'b0;
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
            r_out      <= '0;
            g_out      <= '0;
            b_out      <= '0;
        end else begin
            if (w_hs_rise) begin
                r_out_cnt <= '0;
                r_phase   <= 1'b0;
            end else if (ce_out) begin
                if (w_wrap) begin
                    r_out_cnt <= '0;
                    r_phase   <= 1'b1;
                end else if (r_out_cnt != CNT_MAX) begin
                    r_out_cnt <= r_out_cnt + ADDR_W'(1);
                end
            end
            if (ce_out) begin
                r_p1_hs    <= r_out_cnt < r_hs_width;
                r_p1_vs    <= r_vs_line;
                r_p1_phase <= r_phase;
                r_p1_valid <= r_line_len != '0;
                hs_out     <= r_p1_hs;
                vs_out     <= r_p1_vs;
                r_out      <= r_p1_valid ? w_pix.r : '0;
                g_out      <= r_p1_valid ? w_pix.g : '0;
                b_out      <= r_p1_valid ? w_pix.b : '0;
            end
        end
    end

endmodule
